// File: rtl/fell_event_arbiter_if.sv
// Event port between the falling-edge arbiter and its consumer (logger / IRQ collector).
interface fell_event_arbiter_if #(
  parameter int N = 4
) ();
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/fell_event_arbiter.sv
// Falling-edge detector with saturating per-line pending counters and a
// round-robin shared event port.
//
// state | meaning
// IDLE  | no offer up; pick next pending line after rr_q
// OFFER | evt_valid high, evt_id held until accepted
module fell_event_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         sig_in_i,
  input  logic [N-1:0]         ovf_clr_i,
  output logic                 pend_any_o,
  output logic [N-1:0]         ovf_o,
  fell_event_arbiter_if.master evt
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [N-1:0]            prev_q;
  logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]            ovf_q, ovf_d;
  logic                    pend_q, pend_d;
  logic [IDW-1:0]          rr_q, rr_d;
  logic [IDW-1:0]          id_q, id_d;

  logic                    accept;
  logic [N-1:0]            fell;
  logic [N-1:0]            dec;
  logic                    pick_found;
  logic [IDW-1:0]          pick_id;
  logic [IDW-1:0]          idx;

  assign accept = (state_q == OFFER) && evt.evt_ready;
  assign fell   = prev_q & ~sig_in_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
      pend_q  <= 1'b0;
      rr_q    <= IDW'(N - 1);
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= sig_in_i;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
    end
  end

  // An edge coinciding with its own line's grant cancels out and never overflows.
  always_comb begin
    dec   = '0;
    cnt_d = cnt_q;
    ovf_d = ovf_q & ~ovf_clr_i;
    for (int i = 0; i < N; i++) begin
      dec[i] = accept && (id_q == IDW'(i));
      if (fell[i] && !dec[i]) begin
        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
        else                     ovf_d[i] = 1'b1;
      end else if (!fell[i] && dec[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
    pend_d = |cnt_d;
  end

  // Search starts just after the last granted line.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int j = 1; j <= N; j++) begin
      idx = IDW'((int'(rr_q) + j) % N);
      if (!pick_found && (cnt_q[idx] != '0)) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OFFER;
          id_d    = pick_id;
        end
      end
      OFFER: begin
        if (evt.evt_ready) begin
          state_d = IDLE;
          rr_d    = id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    evt.evt_valid = (state_q == OFFER);
    evt.evt_id    = id_q;
    pend_any_o    = pend_q;
    ovf_o         = ovf_q;
  end
endmodule
